rr_switch_arbiter: RTL and testbench

Parametrised round-robin arbiter and datapath that moves words from N_IN first-word-fall-through input FIFOs to N_OUT output FIFOs. Each word is routed by a destination field in the word.

- It sits between the input and output FIFO banks of the switch and replaces the fixed-priority, push-all arbiter.
- It adds per-destination backpressure, fair arbitration, an internal data mux and discard of words with an invalid destination.

---
 rtl/rr_switch_arbiter.sv | 111 +++++++++++
 tb/tb_rr_switch_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_switch_arbiter.sv
// Round-robin arbiter and datapath between the switch's input and output FIFO banks.
// Routes each head word by its destination field and discards words with an invalid destination.
module rr_switch_arbiter #(
    parameter  int N_IN     = 4,
    parameter  int N_OUT    = 4,
    parameter  int DATA_W   = 10,
    parameter  int DEST_W   = 2,
    parameter  int DEST_LSB = 8,
    parameter  int CNT_W    = 8,
    localparam int SEL_W    = $clog2(N_IN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_IN-1:0]          empty,
    input  logic [N_IN*DATA_W-1:0]   data_in,
    input  logic [N_OUT-1:0]         almost_full,
    output logic [N_IN-1:0]          pop,
    output logic [N_OUT-1:0]         push,
    output logic [DATA_W-1:0]        data_out,
    output logic [SEL_W-1:0]         select,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int N_DEST = 2 ** DEST_W;

    logic [N_IN-1:0]   r_pop;
    logic [N_OUT-1:0]  r_push;
    logic [DATA_W-1:0] r_data;
    logic [SEL_W-1:0]  r_sel;
    logic [SEL_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_drop;

    logic [DATA_W-1:0] w_head [N_IN];
    logic [DEST_W-1:0] w_dest [N_IN];
    logic [N_IN-1:0]   w_dest_ok;
    logic [N_IN-1:0]   w_elig;
    logic [N_DEST-1:0] w_af_ext;

    logic              w_found;
    logic [SEL_W-1:0]  w_grant;
    logic [SEL_W-1:0]  w_ptr_nxt;
    logic              w_g_ok;
    logic [N_IN-1:0]   w_pop_nxt;
    logic [N_DEST-1:0] w_push_ext;
    logic [N_OUT-1:0]  w_push_nxt;

    // Widen almost_full to the full destination range so any dest value indexes safely.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_af_ext              = '0;
        w_af_ext[N_OUT-1:0]   = almost_full;
    end

    // A head whose pop is in flight is stale, so its channel sits out this cycle.
    for (genvar i = 0; i < N_IN; i++) begin : g_chan
        assign w_head[i]    = data_in[i*DATA_W +: DATA_W];
        assign w_dest[i]    = w_head[i][DEST_LSB +: DEST_W];
        assign w_dest_ok[i] = (int'(w_dest[i]) < N_OUT);
        assign w_elig[i]    = !empty[i] && !r_pop[i] &&
                              (!w_dest_ok[i] || !w_af_ext[w_dest[i]]);
    end

    always_comb begin
        int idx;
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < N_IN; k++) begin
            idx = (int'(r_ptr) + k) % N_IN;
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_grant = SEL_W'(idx);
            end
        end
    end

    assign w_g_ok     = w_dest_ok[w_grant];
    assign w_ptr_nxt  = (w_grant == SEL_W'(N_IN - 1)) ? '0 : w_grant + 1'b1;
    assign w_pop_nxt  = w_found ? (N_IN'(1) << w_grant) : '0;
    assign w_push_ext = (w_found && w_g_ok) ? (N_DEST'(1) << w_dest[w_grant]) : '0;
    assign w_push_nxt = w_push_ext[N_OUT-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_pop  <= '0;
            r_push <= '0;
            r_data <= '0;
            r_sel  <= '0;
            r_ptr  <= '0;
            r_drop <= '0;
        end else begin
            r_pop  <= w_pop_nxt;
            r_push <= w_push_nxt;
            if (w_found) begin
                r_sel <= w_grant;
                r_ptr <= w_ptr_nxt;
                if (w_g_ok)
                    r_data <= w_head[w_grant];
                else if (r_drop != '1)
                    r_drop <= r_drop + 1'b1;
            end
        end
    end

    assign pop      = r_pop;
    assign push     = r_push;
    assign data_out = r_data;
    assign select   = r_sel;
    assign drop_cnt = r_drop;

endmodule

// File: tb/tb_rr_switch_arbiter.sv
// Randomised bench for rr_switch_arbiter: input FIFOs are queues, expected outputs come
// from a per-cycle model of the arbitration rules.
module tb_rr_switch_arbiter;

    localparam int N_IN     = 4;
    localparam int N_OUT    = 3;
    localparam int DATA_W   = 10;
    localparam int DEST_W   = 2;
    localparam int DEST_LSB = 8;
    localparam int CNT_W    = 8;
    localparam int SEL_W    = 2;
    localparam int CNT_MAX  = 2 ** CNT_W - 1;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [N_IN-1:0]        empty;
    logic [N_IN*DATA_W-1:0] data_in;
    logic [N_OUT-1:0]       almost_full;
    logic [N_IN-1:0]        pop;
    logic [N_OUT-1:0]       push;
    logic [DATA_W-1:0]      data_out;
    logic [SEL_W-1:0]       select;
    logic [CNT_W-1:0]       drop_cnt;

    always #5 clk = ~clk;

    rr_switch_arbiter #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W),
        .DEST_W(DEST_W), .DEST_LSB(DEST_LSB), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .empty(empty), .data_in(data_in),
        .almost_full(almost_full), .pop(pop), .push(push),
        .data_out(data_out), .select(select), .drop_cnt(drop_cnt)
    );

    // Input FIFO contents and the expected registered outputs.
    logic [DATA_W-1:0] q [N_IN][$];
    logic [N_IN-1:0]   m_pop  = '0;
    logic [N_OUT-1:0]  m_push = '0;
    logic [DATA_W-1:0] m_data = '0;
    int                m_sel  = 0;
    int                m_ptr  = 0;
    int                m_drop = 0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic int dest_of(input logic [DATA_W-1:0] w);
        return int'(w[DEST_LSB +: DEST_W]);
    endfunction

    function automatic logic [DATA_W-1:0] mk(input int d);
        logic [DATA_W-1:0] w;
        w = DATA_W'($urandom);
        w[DEST_LSB +: DEST_W] = DEST_W'(d);
        return w;
    endfunction

    function automatic bit idle();
        bit r;
        r = (m_pop == '0);
        for (int c = 0; c < N_IN; c++) if (q[c].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic drive();
        for (int c = 0; c < N_IN; c++) begin
            if (q[c].size() == 0) begin
                empty[c] = 1'b1;
                data_in[c*DATA_W +: DATA_W] = DATA_W'($urandom);
            end else begin
                empty[c] = 1'b0;
                data_in[c*DATA_W +: DATA_W] = q[c][0];
            end
        end
    endtask

    // One clock: predict from current inputs, let the edge happen, let the FIFOs act, compare.
    task automatic step();
        logic [N_IN-1:0]   cur_pop;
        logic [N_IN-1:0]   n_pop;
        logic [N_OUT-1:0]  n_push;
        logic [DATA_W-1:0] n_data;
        int n_sel, n_ptr, n_drop, c, d;
        bit found;
        cur_pop = m_pop;
        n_pop = '0; n_push = '0;
        if (!reset) begin
            n_data = '0; n_sel = 0; n_ptr = 0; n_drop = 0;
        end else begin
            n_data = m_data; n_sel = m_sel; n_ptr = m_ptr; n_drop = m_drop;
            found = 1'b0;
            for (int k = 0; k < N_IN; k++) begin
                c = (m_ptr + k) % N_IN;
                if (!found && q[c].size() > 0 && !m_pop[c]) begin
                    d = dest_of(q[c][0]);
                    if (d >= N_OUT || !almost_full[d]) begin
                        found = 1'b1;
                        n_pop[c] = 1'b1;
                        n_sel = c;
                        n_ptr = (c + 1) % N_IN;
                        if (d < N_OUT) begin
                            n_push[d] = 1'b1;
                            n_data = q[c][0];
                        end else begin
                            n_drop = (m_drop == CNT_MAX) ? CNT_MAX : m_drop + 1;
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N_IN; i++) if (cur_pop[i]) void'(q[i].pop_front());
        m_pop = n_pop; m_push = n_push; m_data = n_data;
        m_sel = n_sel; m_ptr = n_ptr; m_drop = n_drop;
        check("pop", 32'(pop), 32'(m_pop));
        check("push", 32'(push), 32'(m_push));
        check("data_out", 32'(data_out), 32'(m_data));
        check("select", 32'(select), m_sel);
        check("drop_cnt", 32'(drop_cnt), m_drop);
        drive();
    endtask

    task automatic drain();
        almost_full = '0;
        drive();
        for (int n = 0; n < 200; n++) if (!idle()) step();
    endtask

    initial begin
        int cnt;
        almost_full = '0;
        for (int c = 0; c < N_IN; c++)
            for (int k = 0; k < 8; k++) q[c].push_back(mk(c % N_OUT));
        drive();

        // Reset held with every FIFO non-empty, then round-robin over all channels.
        repeat (3) step();
        reset = 1'b1;
        step();
        check("first_grant_sel", 32'(select), 0);
        check("first_grant_pop", 32'(pop), 32'h1);
        repeat (12) step();
        drain();

        // Single channel streaming: one word every two cycles.
        for (int k = 0; k < 4; k++) q[2].push_back(mk(k % N_OUT));
        drive();
        cnt = 0;
        for (int n = 0; n < 8; n++) begin
            step();
            if (|push) cnt++;
        end
        check("stream_pushes", cnt, 4);
        drain();

        // Backpressure on destination 1 while channel 1 keeps flowing.
        q[0].push_back(mk(1));
        q[1].push_back(mk(2));
        q[1].push_back(mk(2));
        almost_full = 3'b010;
        drive();
        repeat (4) step();
        check("bp_held_q0", q[0].size(), 1);
        almost_full = '0;
        step();
        check("bp_pop0", 32'(pop[0]), 1);
        check("bp_push1", 32'(push[1]), 1);
        drain();

        // Reset arriving while a pop/push pair is in flight.
        q[1].push_back(mk(2));
        q[1].push_back(mk(2));
        drive();
        step();
        check("mid_pop1", 32'(pop[1]), 1);
        check("mid_push2", 32'(push[2]), 1);
        q[0].push_back(mk(0));
        drive();
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        step();
        check("post_reset_sel", 32'(select), 0);
        check("post_reset_pop", 32'(pop), 32'h1);
        drain();

        // Invalid destination: discard and saturating drop count.
        for (int c = 0; c < N_IN; c++)
            for (int k = 0; k < 75; k++) q[c].push_back(mk(3));
        drive();
        step();
        check("drop_first", 32'(drop_cnt), 1);
        for (int n = 0; n < 1000; n++) if (!idle()) step();
        check("drop_sat", 32'(drop_cnt), CNT_MAX);

        // Random traffic with random backpressure.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(1, 0) == 1) begin
                int c;
                c = $urandom_range(N_IN - 1, 0);
                if (q[c].size() < 6) q[c].push_back(DATA_W'($urandom));
            end
            for (int b = 0; b < N_OUT; b++) almost_full[b] = ($urandom_range(3, 0) == 0);
            drive();
            step();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
